// File: rtl/rgb_to_ycbcr.sv
// BT.601 RGB -> YCbCr converter: four register stages, one pixel per clock,
// with sof/eol sideband carried alongside and an output-side line-length checker.
module rgb_to_ycbcr #(
  parameter int H_ACTIVE = 640,
  parameter int CNT_W    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  input  logic       in_sof,
  input  logic       in_eol,
  output logic       out_valid,
  output logic [7:0] Y,
  output logic [7:0] Cb,
  output logic [7:0] Cr,
  output logic       out_sof,
  output logic       out_eol,
  output logic       err_line_len
);

  // Handshake: no backpressure. in_valid=1 means the pixel is taken on this
  // edge; out_valid=1 means Y/Cb/Cr/out_sof/out_eol are meaningful this cycle.

  // Bit 0 is S1, bit 3 is the output stage.
  logic [3:0] vld_q, vld_d;
  logic [3:0] sof_q, sof_d;
  logic [3:0] eol_q, eol_d;

  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // Product order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B).
  logic signed [17:0] prod_q [9];
  logic signed [17:0] prod_d [9];

  logic signed [19:0] sum_y_q, sum_y_d, sum_cb_q, sum_cb_d, sum_cr_q, sum_cr_d;

  logic [7:0] y_q, y_d, cb_q, cb_d, cr_q, cr_d;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic             err_q, err_d;

  function automatic logic signed [17:0] mulc(input logic [7:0] x,
                                              input logic signed [17:0] k);
    logic signed [17:0] xe;
    xe = $signed({10'd0, x});
    return xe * k;
  endfunction

  function automatic logic signed [19:0] sx20(input logic signed [17:0] x);
    return $signed({{2{x[17]}}, x});
  endfunction

  // Dropping the low 8 bits of a two's-complement sum is a floor shift.
  function automatic logic [7:0] scale_clamp(input logic signed [19:0] s,
                                             input logic signed [12:0] offs,
                                             input logic signed [12:0] lo,
                                             input logic signed [12:0] hi);
    logic signed [12:0] v;
    v = $signed({s[19], s[19:8]}) + offs;
    if (v < lo)      return lo[7:0];
    else if (v > hi) return hi[7:0];
    else             return v[7:0];
  endfunction

  always_comb begin
    vld_d = {vld_q[2:0], in_valid};
    sof_d = {sof_q[2:0], in_valid & in_sof};
    eol_d = {eol_q[2:0], in_valid & in_eol};

    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (in_valid) begin
      r_d = in_R;
      g_d = in_G;
      b_d = in_B;
    end

    for (int i = 0; i < 9; i++) prod_d[i] = prod_q[i];
    if (vld_q[0]) begin
      prod_d[0] = mulc(r_q,  18'sd66);
      prod_d[1] = mulc(g_q,  18'sd129);
      prod_d[2] = mulc(b_q,  18'sd25);
      prod_d[3] = mulc(r_q, -18'sd38);
      prod_d[4] = mulc(g_q, -18'sd74);
      prod_d[5] = mulc(b_q,  18'sd112);
      prod_d[6] = mulc(r_q,  18'sd112);
      prod_d[7] = mulc(g_q, -18'sd94);
      prod_d[8] = mulc(b_q, -18'sd18);
    end

    sum_y_d  = sum_y_q;
    sum_cb_d = sum_cb_q;
    sum_cr_d = sum_cr_q;
    if (vld_q[1]) begin
      sum_y_d  = sx20(prod_q[0]) + sx20(prod_q[1]) + sx20(prod_q[2]) + 20'sd128;
      sum_cb_d = sx20(prod_q[3]) + sx20(prod_q[4]) + sx20(prod_q[5]) + 20'sd128;
      sum_cr_d = sx20(prod_q[6]) + sx20(prod_q[7]) + sx20(prod_q[8]) + 20'sd128;
    end

    y_d  = y_q;
    cb_d = cb_q;
    cr_d = cr_q;
    if (vld_q[2]) begin
      y_d  = scale_clamp(sum_y_q,  13'sd16,  13'sd16, 13'sd235);
      cb_d = scale_clamp(sum_cb_q, 13'sd128, 13'sd16, 13'sd240);
      cr_d = scale_clamp(sum_cr_q, 13'sd128, 13'sd16, 13'sd240);
    end

    // Count including the pixel currently on the output; sof restarts the line.
    if (sof_q[3])     cnt_cur = CNT_W'(1);
    else if (&cnt_q)  cnt_cur = cnt_q;
    else              cnt_cur = cnt_q + 1'b1;

    cnt_d = cnt_q;
    err_d = 1'b0;
    if (vld_q[3]) begin
      cnt_d = cnt_cur;
      if (eol_q[3]) begin
        err_d = (cnt_cur != CNT_W'(H_ACTIVE));
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      sof_q    <= '0;
      eol_q    <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      sum_y_q  <= '0;
      sum_cb_q <= '0;
      sum_cr_q <= '0;
      y_q      <= 8'd16;
      cb_q     <= 8'd128;
      cr_q     <= 8'd128;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      sum_y_q  <= sum_y_d;
      sum_cb_q <= sum_cb_d;
      sum_cr_q <= sum_cr_d;
      y_q      <= y_d;
      cb_q     <= cb_d;
      cr_q     <= cr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign out_valid    = vld_q[3];
  assign out_sof      = sof_q[3];
  assign out_eol      = eol_q[3];
  assign Y            = y_q;
  assign Cb           = cb_q;
  assign Cr           = cr_q;
  assign err_line_len = err_q;

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Directed bench for rgb_to_ycbcr: reset values, colour vectors, bubbles,
// line-length checker and mid-stream reset, with hand-computed expectations.
module tb_rgb_to_ycbcr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_R, in_G, in_B;
  logic       in_sof, in_eol;
  logic       out_valid;
  logic [7:0] Y, Cb, Cr;
  logic       out_sof, out_eol;
  logic       err_line_len;

  int total = 0;
  int bad   = 0;

  rgb_to_ycbcr #(.H_ACTIVE(8), .CNT_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_R         (in_R),
    .in_G         (in_G),
    .in_B         (in_B),
    .in_sof       (in_sof),
    .in_eol       (in_eol),
    .out_valid    (out_valid),
    .Y            (Y),
    .Cb           (Cb),
    .Cr           (Cr),
    .out_sof      (out_sof),
    .out_eol      (out_eol),
    .err_line_len (err_line_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic s, input logic e);
    in_valid = v;
    in_R     = r;
    in_G     = g;
    in_B     = b;
    in_sof   = s;
    in_eol   = e;
  endtask

  task automatic expect_px(input string tag, input logic v, input logic [7:0] y,
                           input logic [7:0] cb, input logic [7:0] cr);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_y"},     32'(Y),  32'(y));
    chk({tag, "_cb"},    32'(Cb), 32'(cb));
    chk({tag, "_cr"},    32'(Cr), 32'(cr));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    expect_px("reset", 1'b0, 8'd16, 8'd128, 8'd128);
    chk("reset_err", 32'(err_line_len), 32'd0);
    chk("reset_sof", 32'(out_sof), 32'd0);

    // Fill the pipeline, then reset asynchronously with all stages busy.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(10 + i), 8'(50 + i), 8'(200 - i), 1'b0, 1'b0);
      tick();
    end
    chk("full_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    expect_px("async_rst", 1'b0, 8'd16, 8'd128, 8'd128);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_px("post_rst_idle", 1'b0, 8'd16, 8'd128, 8'd128);
    end

    // Back-to-back pixels.
    drive(1'b1, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0); tick();
    drive(1'b1, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd255, 8'd0,   8'd0,   1'b0, 1'b0); tick();
    drive(1'b1, 8'd0,   8'd255, 8'd0,   1'b0, 1'b0); tick();
    drive(1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0);
    expect_px("black", 1'b1, 8'd16, 8'd128, 8'd128);
    tick(); expect_px("white", 1'b1, 8'd235, 8'd128, 8'd128);
    tick(); expect_px("red",   1'b1, 8'd82,  8'd90,  8'd240);
    tick(); expect_px("green", 1'b1, 8'd144, 8'd54,  8'd34);
    tick(); expect_px("drain", 1'b0, 8'd144, 8'd54,  8'd34);

    // Floor-shift and chroma-ceiling vectors.
    drive(1'b1, 8'd0, 8'd255, 8'd255, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd0, 8'd0,   8'd255, 1'b0, 1'b0); tick();
    drive(1'b0, 8'd0, 8'd0,   8'd0,   1'b0, 1'b0); tick();
    tick();
    expect_px("cyan", 1'b1, 8'd169, 8'd166, 8'd16);
    tick();
    expect_px("blue", 1'b1, 8'd41, 8'd240, 8'd110);

    // Valid pattern 1,0,0,1,1,0; bubbles carry junk data that must not load.
    drive(1'b1, 8'd255, 8'd0,   8'd0,   1'b0, 1'b0); tick();
    drive(1'b0, 8'd77,  8'd88,  8'd99,  1'b1, 1'b1); tick();
    drive(1'b0, 8'd12,  8'd34,  8'd56,  1'b0, 1'b0); tick();
    drive(1'b1, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0); tick();
    expect_px("bub0", 1'b1, 8'd82, 8'd90, 8'd240);
    drive(1'b1, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0); tick();
    expect_px("bub1", 1'b0, 8'd82, 8'd90, 8'd240);
    chk("bub1_sof", 32'(out_sof), 32'd0);
    chk("bub1_eol", 32'(out_eol), 32'd0);
    drive(1'b0, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0); tick();
    expect_px("bub2", 1'b0, 8'd82, 8'd90, 8'd240);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0); tick();
    expect_px("bub3", 1'b1, 8'd16, 8'd128, 8'd128);
    tick(); expect_px("bub4", 1'b1, 8'd235, 8'd128, 8'd128);
    tick(); expect_px("bub5", 1'b0, 8'd235, 8'd128, 8'd128);
    tick();
    tick();

    // An 8-pixel line (correct) followed directly by a 7-pixel line (short).
    for (int t = 1; t <= 22; t++) begin
      int d;
      int o;
      d = t - 1;
      o = t - 4;
      if (d < 15)
        drive(1'b1, 8'(d * 9), 8'(d * 5), 8'(d * 3), (d == 0 || d == 8), (d == 7 || d == 14));
      else
        drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      if (o >= 0 && o < 15) begin
        chk("line_valid", 32'(out_valid), 32'd1);
        chk("line_sof",   32'(out_sof),   32'(o == 0 || o == 8));
        chk("line_eol",   32'(out_eol),   32'(o == 7 || o == 14));
      end else begin
        chk("line_idle", 32'(out_valid), 32'd0);
      end
      chk("line_err", 32'(err_line_len), 32'(t - 5 == 14));
    end

    // Three pixels in flight (last one a too-short eol) are flushed by reset.
    drive(1'b1, 8'd100, 8'd100, 8'd100, 1'b1, 1'b0); tick();
    drive(1'b1, 8'd150, 8'd50,  8'd25,  1'b0, 1'b0); tick();
    drive(1'b1, 8'd30,  8'd60,  8'd90,  1'b0, 1'b1); tick();
    drive(1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0);
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_err",   32'(err_line_len), 32'd0);
    end
    chk("flush_y", 32'(Y), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
